// File: rtl/lane_arbiter.sv
// lane_arbiter
//   Merges two first-word-fall-through lane FIFOs into one byte stream.
//   Grants are issued in bursts of up to burst_max+1 bytes to one lane
//   while the other lane waits. Downstream backpressure pauses popping.
//
// Ports
//   clk_2f           in   sole clock, rising edge
//   reset            in   asynchronous, active-high
//   burst_max        in   BURST_W  burst length minus one
//   fifo_empty_0/1   in   lane FIFO empty flags
//   fifo_data_0/1    in   8  lane FIFO head data (valid when not empty)
//   almost_full_out  in   downstream backpressure, 1 forbids pops
//   pop_0/pop_1      out  combinational pop strobes, mutually exclusive
//   data_out         out  8  registered merged byte
//   valid_out        out  registered, data_out holds a byte popped last cycle
//   active_lane      out  registered lane of the most recent grant
//   state            out  3  registered FSM state
//   idle             out  combinational, 1 iff state is IDLE
module lane_arbiter #(
    parameter int BURST_W = 2
) (
    input  logic               clk_2f,
    input  logic               reset,
    input  logic [BURST_W-1:0] burst_max,
    input  logic               fifo_empty_0,
    input  logic               fifo_empty_1,
    input  logic [7:0]         fifo_data_0,
    input  logic [7:0]         fifo_data_1,
    input  logic               almost_full_out,
    output logic               pop_0,
    output logic               pop_1,
    output logic [7:0]         data_out,
    output logic               valid_out,
    output logic               active_lane,
    output logic [2:0]         state,
    output logic               idle
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_PAUSE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [BURST_W:0] burst_len_q, burst_len_d;
    logic [BURST_W:0] burst_cnt_q, burst_cnt_d;
    logic             active_lane_q, active_lane_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;

    logic             cur_ne, oth_ne, any_ne;
    logic             can_pop;
    logic             grant;
    logic             grant_lane;
    logic [BURST_W:0] cnt_next;

    assign cur_ne  = active_lane_q ? ~fifo_empty_1 : ~fifo_empty_0;
    assign oth_ne  = active_lane_q ? ~fifo_empty_0 : ~fifo_empty_1;
    assign any_ne  = ~fifo_empty_0 | ~fifo_empty_1;
    assign can_pop = (state_q == S_ACTIVE) && !almost_full_out;

    // A zero burst count means no burst is open (after reset or IDLE), so the
    // current lane is not preferred; this makes lane 0 win the first grant.
    always_comb begin
        grant      = 1'b0;
        grant_lane = active_lane_q;
        cnt_next   = burst_cnt_q;
        if (can_pop) begin
            if (cur_ne && (burst_cnt_q != '0) && (burst_cnt_q < burst_len_q)) begin
                grant      = 1'b1;
                grant_lane = active_lane_q;
                cnt_next   = burst_cnt_q + 1'b1;
            end else if (oth_ne) begin
                grant      = 1'b1;
                grant_lane = ~active_lane_q;
                cnt_next   = (BURST_W+1)'(1);
            end else if (cur_ne) begin
                grant      = 1'b1;
                grant_lane = active_lane_q;
                cnt_next   = (BURST_W+1)'(1);
            end
        end
    end

    assign pop_0 = grant & ~grant_lane;
    assign pop_1 = grant &  grant_lane;

    always_comb begin
        state_d       = state_q;
        burst_len_d   = burst_len_q;
        burst_cnt_d   = burst_cnt_q;
        active_lane_d = active_lane_q;
        valid_d       = grant;
        data_d        = data_q;

        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                state_d     = S_IDLE;
                burst_len_d = (BURST_W+1)'(burst_max) + (BURST_W+1)'(1);
            end
            S_IDLE: begin
                burst_len_d = (BURST_W+1)'(burst_max) + (BURST_W+1)'(1);
                burst_cnt_d = '0;
                if (any_ne) state_d = almost_full_out ? S_PAUSE : S_ACTIVE;
            end
            S_ACTIVE: begin
                if (almost_full_out) state_d = S_PAUSE;
                else if (!any_ne)    state_d = S_IDLE;
            end
            S_PAUSE: begin
                if (!almost_full_out) state_d = any_ne ? S_ACTIVE : S_IDLE;
            end
            default: state_d = S_RESET;
        endcase

        if (grant) begin
            burst_cnt_d   = cnt_next;
            active_lane_d = grant_lane;
            data_d        = grant_lane ? fifo_data_1 : fifo_data_0;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q       <= S_RESET;
            burst_len_q   <= (BURST_W+1)'(1);
            burst_cnt_q   <= '0;
            active_lane_q <= 1'b1;
            valid_q       <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            burst_len_q   <= burst_len_d;
            burst_cnt_q   <= burst_cnt_d;
            active_lane_q <= active_lane_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign active_lane = active_lane_q;
    assign state       = state_q;
    assign idle        = (state_q == S_IDLE);

endmodule

// File: tb/tb_lane_arbiter.sv
module tb_lane_arbiter;

    logic       clk_2f = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] burst_max = '0;
    logic       fifo_empty_0 = 1'b1;
    logic       fifo_empty_1 = 1'b1;
    logic [7:0] fifo_data_0 = '0;
    logic [7:0] fifo_data_1 = '0;
    logic       almost_full_out = 1'b0;
    logic       pop_0, pop_1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_lane;
    logic [2:0] state;
    logic       idle;

    lane_arbiter #(.BURST_W(2)) dut (
        .clk_2f          (clk_2f),
        .reset           (reset),
        .burst_max       (burst_max),
        .fifo_empty_0    (fifo_empty_0),
        .fifo_empty_1    (fifo_empty_1),
        .fifo_data_0     (fifo_data_0),
        .fifo_data_1     (fifo_data_1),
        .almost_full_out (almost_full_out),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .active_lane     (active_lane),
        .state           (state),
        .idle            (idle)
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct packed {
        logic       lane;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       glog[$];
    logic       vhist[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic refresh();
        fifo_empty_0 = (q0.size() == 0);
        fifo_data_0  = fifo_empty_0 ? 8'h00 : q0[0];
        fifo_empty_1 = (q1.size() == 0);
        fifo_data_1  = fifo_empty_1 ? 8'h00 : q1[0];
    endtask

    task automatic load(input int n0, input logic [7:0] base0, input int n1, input logic [7:0] base1);
        for (int i = 0; i < n0; i++) q0.push_back(base0 + 8'(i));
        for (int i = 0; i < n1; i++) q1.push_back(base1 + 8'(i));
        refresh();
    endtask

    // One clock: check the registered outputs against the scoreboard, record
    // any pop seen before the edge, then let the FIFO model retire it.
    task automatic step();
        exp_t e;
        logic p0, p1;
        @(negedge clk_2f);
        vhist.push_back(valid_out);
        vectors++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (valid_out !== 1'b1 || data_out !== e.data || active_lane !== e.lane) begin
                miscompares++;
                $display("FAIL scoreboard: valid=%b data=%h lane=%b, expected valid=1 data=%h lane=%b",
                         valid_out, data_out, active_lane, e.data, e.lane);
            end
        end else if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL no_byte_valid: valid_out=%b expected 0", valid_out);
        end
        p0 = pop_0;
        p1 = pop_1;
        if (p0 === 1'b1 && p1 === 1'b1) begin
            miscompares++;
            $display("FAIL both_pops: pop_0=%b pop_1=%b expected not both 1", p0, p1);
        end
        if ((p0 === 1'b1 && q0.size() == 0) || (p1 === 1'b1 && q1.size() == 0)) begin
            miscompares++;
            $display("FAIL pop_empty: pop_0=%b pop_1=%b on empty FIFO", p0, p1);
        end
        if ((p0 === 1'b1 || p1 === 1'b1) && (state !== 3'd3 || almost_full_out)) begin
            miscompares++;
            $display("FAIL pop_gate: pop while state=%0d afo=%b expected ACTIVE and afo=0", state, almost_full_out);
        end
        if (p0 === 1'b1 && q0.size() > 0) begin
            e.lane = 1'b0; e.data = q0[0];
            sb.push_back(e); glog.push_back(1'b0);
        end else if (p1 === 1'b1 && q1.size() > 0) begin
            e.lane = 1'b1; e.data = q1[0];
            sb.push_back(e); glog.push_back(1'b1);
        end
        @(posedge clk_2f);
        #1;
        if (p0 === 1'b1 && q0.size() > 0) q0.delete(0);
        else if (p1 === 1'b1 && q1.size() > 0) q1.delete(0);
        refresh();
    endtask

    task automatic run_until_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            step();
            if (state === 3'd2 && sb.size() == 0 && q0.size() == 0 && q1.size() == 0) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: state=%0d expected IDLE(2) within 200 cycles", name, state);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_2f);
        #1;
        vectors++;
        if (state !== 3'd0 || pop_0 !== 1'b0 || pop_1 !== 1'b0 || valid_out !== 1'b0 ||
            data_out !== 8'h00 || active_lane !== 1'b1 || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: state=%0d pops=%b%b valid=%b data=%h lane=%b idle=%b expected 0 00 0 00 1 0",
                     state, pop_0, pop_1, valid_out, data_out, active_lane, idle);
        end
    endtask

    task automatic test_alternate();
        burst_max = 2'd0;
        load(4, 8'h10, 4, 8'h20);
        #1;
        vectors++;
        if (pop_0 !== 1'b0 || pop_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_in_reset: pops=%b%b expected 00", pop_0, pop_1);
        end
        glog.delete();
        reset = 1'b0;
        step();
        vectors++;
        if (state !== 3'd1) begin miscompares++; $display("FAIL init_state: state=%0d expected 1", state); end
        step();
        vectors++;
        if (state !== 3'd2 || idle !== 1'b1) begin
            miscompares++; $display("FAIL idle_state: state=%0d idle=%b expected 2 1", state, idle);
        end
        step();
        vectors++;
        if (state !== 3'd3 || glog.size() != 0) begin
            miscompares++; $display("FAIL active_state: state=%0d pops=%0d expected 3 0", state, glog.size());
        end
        run_until_idle("alternate");
        vectors++;
        if (glog.size() != 8) begin
            miscompares++; $display("FAIL alternate_count: grants=%0d expected 8", glog.size());
        end
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            vectors++;
            if (glog[i] !== 1'(i % 2)) begin
                miscompares++; $display("FAIL alternate_lane[%0d]: lane=%b expected %b", i, glog[i], 1'(i % 2));
            end
        end
    endtask

    task automatic test_burst();
        int ones, rises;
        burst_max = 2'd2;
        glog.delete();
        vhist.delete();
        load(6, 8'h30, 6, 8'h40);
        run_until_idle("burst");
        vectors++;
        if (glog.size() != 12) begin
            miscompares++; $display("FAIL burst_count: grants=%0d expected 12", glog.size());
        end
        for (int i = 0; i < 12 && i < glog.size(); i++) begin
            vectors++;
            if (glog[i] !== 1'((i / 3) % 2)) begin
                miscompares++; $display("FAIL burst_lane[%0d]: lane=%b expected %b", i, glog[i], 1'((i / 3) % 2));
            end
        end
        ones = 0;
        rises = 0;
        for (int i = 0; i < vhist.size(); i++) begin
            if (vhist[i] === 1'b1) ones++;
            if (vhist[i] === 1'b1 && (i == 0 || vhist[i-1] !== 1'b1)) rises++;
        end
        vectors++;
        if (ones != 12 || rises != 1) begin
            miscompares++; $display("FAIL burst_valid_run: valid cycles=%0d runs=%0d expected 12 1", ones, rises);
        end
        vectors++;
        if (idle !== 1'b1) begin miscompares++; $display("FAIL burst_end_idle: idle=%b expected 1", idle); end
    endtask

    task automatic test_single_lane();
        burst_max = 2'd0;
        glog.delete();
        q1.push_back(8'hAA); q1.push_back(8'hBB); q1.push_back(8'hCC); q1.push_back(8'hDD);
        refresh();
        run_until_idle("single");
        vectors++;
        if (glog.size() != 4) begin
            miscompares++; $display("FAIL single_count: grants=%0d expected 4", glog.size());
        end
        for (int i = 0; i < glog.size(); i++) begin
            vectors++;
            if (glog[i] !== 1'b1) begin
                miscompares++; $display("FAIL single_lane[%0d]: lane=%b expected 1", i, glog[i]);
            end
        end
        vectors++;
        if (data_out !== 8'hDD) begin miscompares++; $display("FAIL single_last: data_out=%h expected dd", data_out); end
    endtask

    task automatic test_backpressure();
        burst_max = 2'd0;
        glog.delete();
        load(4, 8'h50, 4, 8'h60);
        repeat (3) step();
        vectors++;
        if (glog.size() != 2) begin
            miscompares++; $display("FAIL bp_pre_count: grants=%0d expected 2", glog.size());
        end
        almost_full_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (state !== 3'd4) begin miscompares++; $display("FAIL bp_state[%0d]: state=%0d expected 4", i, state); end
        end
        vectors++;
        if (glog.size() != 2) begin
            miscompares++; $display("FAIL bp_blocked: grants=%0d expected 2", glog.size());
        end
        almost_full_out = 1'b0;
        run_until_idle("backpressure");
        vectors++;
        if (glog.size() != 8) begin
            miscompares++; $display("FAIL bp_count: grants=%0d expected 8", glog.size());
        end
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            vectors++;
            if (glog[i] !== 1'(i % 2)) begin
                miscompares++; $display("FAIL bp_lane[%0d]: lane=%b expected %b", i, glog[i], 1'(i % 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        burst_max = 2'd0;
        glog.delete();
        load(4, 8'h70, 4, 8'h80);
        step();
        #1;
        vectors++;
        if (pop_0 !== 1'b1) begin miscompares++; $display("FAIL mid_pop0: pop_0=%b expected 1", pop_0); end
        reset = 1'b1;
        #1;
        vectors++;
        if (pop_0 !== 1'b0 || pop_1 !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00 ||
            state !== 3'd0 || active_lane !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: pops=%b%b valid=%b data=%h state=%0d lane=%b expected 00 0 00 0 1",
                     pop_0, pop_1, valid_out, data_out, state, active_lane);
        end
        @(posedge clk_2f);
        #1;
        reset = 1'b0;
        step();
        vectors++;
        if (state !== 3'd1) begin miscompares++; $display("FAIL mid_init: state=%0d expected 1", state); end
        step();
        vectors++;
        if (state !== 3'd2) begin miscompares++; $display("FAIL mid_idle: state=%0d expected 2", state); end
        run_until_idle("reset_mid");
        vectors++;
        if (glog.size() != 8) begin
            miscompares++; $display("FAIL mid_count: grants=%0d expected 8", glog.size());
        end
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            vectors++;
            if (glog[i] !== 1'(i % 2)) begin
                miscompares++; $display("FAIL mid_lane[%0d]: lane=%b expected %b", i, glog[i], 1'(i % 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_burst();
        test_single_lane();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
